seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit stays lit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port load_valid  input  1  requester offers new 4-digit BCD value.
REQ-005 SHALL have port load_data  input  16  digit i = load_data[4i+3:4i], digit 0 rightmost.
REQ-006 SHALL have port load_ready  output  1  controller can accept load_data this cycle.
REQ-007 SHALL have port dec_b  output  4  BCD nibble driven to the shared 4-bit-to-7-segment decoder.
REQ-008 SHALL have port dec_h  input  7  active-low segment pattern returned combinationally by that decoder (pattern 7'h7F for nibbles 10..15).
REQ-009 SHALL have port seg_out  output  7  registered active-low segment bus to the display.
REQ-010 SHALL have port an  output  4  registered active-low digit enables; at most one bit low.

Function
REQ-011 SHALL run a divider div from 0 to SCAN_DIV-1, wrapping to 0; at div==SCAN_DIV-1 the digit index idx SHALL advance 0->1->2->3->0.
REQ-012 SHALL define the frame boundary as the cycle with div==SCAN_DIV-1 and idx==3.
REQ-013 SHALL drive dec_b combinationally from the display register nibble selected by idx; one decoder instance is shared across all digits.
REQ-014 SHALL, in state SCAN, register seg_out<=dec_h and an<=~(4'b0001<<idx) every cycle, giving seg_out/an one cycle of latency behind idx.
REQ-015 SHALL implement states BLANK and SCAN; BLANK holds an=4'b1111 and seg_out=7'h7F while div/idx keep running; BLANK->SCAN on the first commit; there is no SCAN->BLANK transition except reset.
REQ-016 SHALL accept a load when load_valid && load_ready, capturing load_data into a shadow register and setting pending.
REQ-017 SHALL drive load_ready = !pending (registered state, no combinational path from load_valid).
REQ-018 SHALL, on a frame boundary with pending set, copy shadow into the display register and clear pending; load_ready rises the following cycle.
REQ-019 SHALL treat a load accepted on the frame-boundary cycle itself as pending until the next frame boundary; it is not committed in the same cycle.
REQ-020 SHALL never change the display register mid-frame; each frame shows one value across all four digits.
REQ-021 SHALL pass nibbles 10..15 to the decoder unchanged; the digit is lit with pattern 7'h7F (blank).

Reset
REQ-022 SHALL, while rst_n is low at a clock edge, set div=0, idx=0, state=BLANK, pending=0, shadow=0, display=0, an=4'b1111, seg_out=7'h7F, load_ready=1 on the next cycle.
REQ-023 SHALL discard any pending shadow value when reset is asserted mid-frame or mid-handshake.

Configuration
REQ-024 SHALL support macro SEG7_LZ_BLANK_EN for leading-zero blanking.
REQ-025 With SEG7_LZ_BLANK_EN defined: in SCAN, digit k (k=3..1) SHALL show seg_out=7'h7F when it and all higher digits are 0. Its an bit still goes low. Digit 0 is never blanked.
REQ-026 Without SEG7_LZ_BLANK_EN: every digit SHALL show dec_h unmodified.

Verification (SCAN_DIV=4; cycle 0 = first cycle after rst_n released)
REQ-027 Reset, no loads for 48 cycles -> an=4'b1111, seg_out=7'h7F, load_ready=1 throughout.
REQ-028 load_valid=1 with load_data=16'h1234 at cycle 2 -> load_ready=0 on cycles 3..15 and 1 from cycle 16. From cycle 17: an=1110/seg_out=7'b1001100 for 4 cycles, then 1101/7'b0000110, 1011/7'b0010010, 0111/7'b1001111, repeating.
REQ-029 Load 16'h1111 at cycle 2, then hold load_valid with 16'h2222 -> 16'h2222 is accepted at cycle 16 and first displayed at cycle 33. Cycles 17..32 show all ones (7'b1001111).
REQ-030 Load 16'h00A0 -> while an=1101, seg_out=7'h7F; other digits show 0 (7'b0000001), macro undefined.
REQ-031 Load 16'h1234, then pull rst_n low at cycle 22 -> cycle 23 shows all reset values, and the display stays blank until a new load commits.
REQ-032 SEG7_LZ_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 show 7'h7F, digit 1 shows 7'b0100100, digit 0 shows 7'b0000001. Load 16'h0000 -> only digit 0 shows 7'b0000001.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with framed, glitch-free loads.
// Define SEG7_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  dec_b,
  input  logic [6:0]  dec_h,
  output logic [6:0]  seg_out,
  output logic [3:0]  an
);

  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

  typedef enum logic {
    BLANK,
    SCAN
  } state_t;

  state_t      state;
  logic [15:0] div;
  logic [1:0]  idx;
  logic        pending;
  logic [15:0] shadow;
  logic [15:0] disp;
  logic        wrap;
  logic        frame_end;
  logic        lz;

  assign wrap       = (div == DIV_MAX);
  assign frame_end  = wrap && (idx == 2'd3);
  assign load_ready = !pending;

  always_comb begin
    dec_b = disp[3:0];
    unique case (idx)
      2'd0: dec_b = disp[3:0];
      2'd1: dec_b = disp[7:4];
      2'd2: dec_b = disp[11:8];
      2'd3: dec_b = disp[15:12];
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  // A digit is blank when it and every digit to its left are zero.
  always_comb begin
    lz = 1'b0;
    unique case (idx)
      2'd3: lz = (disp[15:12] == 4'd0);
      2'd2: lz = (disp[15:8] == 8'd0);
      2'd1: lz = (disp[15:4] == 12'd0);
      2'd0: lz = 1'b0;
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div     <= '0;
      idx     <= '0;
      state   <= BLANK;
      pending <= 1'b0;
      shadow  <= '0;
      disp    <= '0;
      an      <= 4'hF;
      seg_out <= 7'h7F;
    end else begin
      div <= wrap ? '0 : div + 16'd1;
      if (wrap) begin
        idx <= idx + 2'd1;
      end
      // Commit only between frames; a load on the boundary waits a frame.
      if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
        state   <= SCAN;
      end else if (load_valid && !pending) begin
        shadow  <= load_data;
        pending <= 1'b1;
      end
      if (state == SCAN) begin
        an      <= ~(4'b0001 << idx);
        seg_out <= lz ? 7'h7F : dec_h;
      end else begin
        an      <= 4'hF;
        seg_out <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at SCAN_DIV=4.
// Cycle 0 is the first cycle after rst_n is released.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [3:0]  dec_b;
  logic [6:0]  dec_h;
  logic [6:0]  seg_out;
  logic [3:0]  an;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0] an_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] ZLZ = 7'h7F;
`else
  localparam logic [6:0] ZLZ = 7'b0000001;
`endif

  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .dec_b(dec_b),
    .dec_h(dec_h),
    .seg_out(seg_out),
    .an(an)
  );

  always #5 clk = ~clk;

  always_comb begin
    dec_h = 7'h7F;
    case (dec_b)
      4'd0: dec_h = 7'b0000001;
      4'd1: dec_h = 7'b1001111;
      4'd2: dec_h = 7'b0010010;
      4'd3: dec_h = 7'b0000110;
      4'd4: dec_h = 7'b1001100;
      4'd5: dec_h = 7'b0100100;
      4'd6: dec_h = 7'b0100000;
      4'd7: dec_h = 7'b0001111;
      4'd8: dec_h = 7'b0000000;
      4'd9: dec_h = 7'b0000100;
      default: dec_h = 7'h7F;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_data = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    while (cyc <= 48) begin
      total++;
      if (an !== 4'hF || seg_out !== 7'h7F || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset cyc=%0d an=%b seg=%b rdy=%b want 1111/1111111/1",
                 cyc, an, seg_out, load_ready);
      end
      step();
    end
  endtask

  task automatic test_scan_1234();
    logic [6:0] es [4];
    logic [3:0] eb [4];
    int d;
    es = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    eb = '{4'd4, 4'd3, 4'd2, 4'd1};
    do_reset();
    step();
    step();
    load_valid = 1'b1;
    load_data = 16'h1234;
    step();
    load_valid = 1'b0;
    while (cyc <= 48) begin
      total++;
      if (load_ready !== (cyc >= 16)) begin
        bad++;
        $display("FAIL scan1234_rdy cyc=%0d got=%b want=%b",
                 cyc, load_ready, (cyc >= 16));
      end
      if (cyc >= 16) begin
        d = ((cyc - 16) / 4) % 4;
        total++;
        if (dec_b !== eb[d]) begin
          bad++;
          $display("FAIL scan1234_decb cyc=%0d got=%h want=%h",
                   cyc, dec_b, eb[d]);
        end
      end
      if (cyc >= 17) begin
        d = ((cyc - 17) / 4) % 4;
        total++;
        if (an !== an_t[d] || seg_out !== es[d]) begin
          bad++;
          $display("FAIL scan1234 cyc=%0d an=%b seg=%b want %b/%b",
                   cyc, an, seg_out, an_t[d], es[d]);
        end
      end else begin
        total++;
        if (an !== 4'hF || seg_out !== 7'h7F) begin
          bad++;
          $display("FAIL scan1234_blank cyc=%0d an=%b seg=%b want 1111/1111111",
                   cyc, an, seg_out);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [6:0] es;
    do_reset();
    step();
    step();
    load_valid = 1'b1;
    load_data = 16'h1111;
    step();
    load_data = 16'h2222;
    while (cyc <= 48) begin
      if (cyc == 17) load_valid = 1'b0;
      total++;
      if (load_ready !== (cyc == 16 || cyc >= 32)) begin
        bad++;
        $display("FAIL b2b_rdy cyc=%0d got=%b want=%b",
                 cyc, load_ready, (cyc == 16 || cyc >= 32));
      end
      if (cyc >= 17) begin
        d = ((cyc - 17) / 4) % 4;
        es = (cyc >= 33) ? 7'b0010010 : 7'b1001111;
        total++;
        if (an !== an_t[d] || seg_out !== es) begin
          bad++;
          $display("FAIL b2b cyc=%0d an=%b seg=%b want %b/%b",
                   cyc, an, seg_out, an_t[d], es);
        end
      end
      step();
    end
  endtask

  task automatic test_boundary_load();
    logic [6:0] es [4];
    int d;
    es = '{7'b0001111, 7'b0000000, 7'b0000100, ZLZ};
    do_reset();
    repeat (15) step();
    load_valid = 1'b1;
    load_data = 16'h0987;
    step();
    load_valid = 1'b0;
    while (cyc <= 48) begin
      total++;
      if (load_ready !== (cyc >= 32)) begin
        bad++;
        $display("FAIL bnd_rdy cyc=%0d got=%b want=%b",
                 cyc, load_ready, (cyc >= 32));
      end
      if (cyc <= 32) begin
        total++;
        if (an !== 4'hF || seg_out !== 7'h7F) begin
          bad++;
          $display("FAIL bnd_blank cyc=%0d an=%b seg=%b want 1111/1111111",
                   cyc, an, seg_out);
        end
      end else begin
        d = ((cyc - 33) / 4) % 4;
        total++;
        if (an !== an_t[d] || seg_out !== es[d]) begin
          bad++;
          $display("FAIL bnd cyc=%0d an=%b seg=%b want %b/%b",
                   cyc, an, seg_out, an_t[d], es[d]);
        end
      end
      step();
    end
  endtask

  task automatic test_nonbcd();
    logic [6:0] es [4];
    int d;
    es = '{7'b0000001, 7'h7F, ZLZ, ZLZ};
    do_reset();
    step();
    step();
    load_valid = 1'b1;
    load_data = 16'h00A0;
    step();
    load_valid = 1'b0;
    while (cyc <= 32) begin
      if (cyc == 20) begin
        total++;
        if (dec_b !== 4'hA) begin
          bad++;
          $display("FAIL nonbcd_decb cyc=%0d got=%h want=a", cyc, dec_b);
        end
      end
      if (cyc >= 17) begin
        d = ((cyc - 17) / 4) % 4;
        total++;
        if (an !== an_t[d] || seg_out !== es[d]) begin
          bad++;
          $display("FAIL nonbcd cyc=%0d an=%b seg=%b want %b/%b",
                   cyc, an, seg_out, an_t[d], es[d]);
        end
      end
      step();
    end
  endtask

  task automatic test_lz();
    logic [6:0] e1 [4];
    logic [6:0] e2 [4];
    logic [6:0] es;
    int d;
    e1 = '{7'b0000001, 7'b0100100, ZLZ, ZLZ};
    e2 = '{7'b0000001, ZLZ, ZLZ, ZLZ};
    do_reset();
    step();
    step();
    load_valid = 1'b1;
    load_data = 16'h0050;
    step();
    load_valid = 1'b0;
    while (cyc <= 48) begin
      if (cyc == 18) begin
        load_valid = 1'b1;
        load_data = 16'h0000;
      end
      if (cyc == 19) load_valid = 1'b0;
      if (cyc >= 17) begin
        d = ((cyc - 17) / 4) % 4;
        es = (cyc >= 33) ? e2[d] : e1[d];
        total++;
        if (an !== an_t[d] || seg_out !== es) begin
          bad++;
          $display("FAIL lz cyc=%0d an=%b seg=%b want %b/%b",
                   cyc, an, seg_out, an_t[d], es);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    step();
    load_valid = 1'b1;
    load_data = 16'h1234;
    step();
    load_valid = 1'b0;
    while (cyc < 22) step();
    total++;
    if (an !== 4'b1101 || seg_out !== 7'b0000110) begin
      bad++;
      $display("FAIL rstmid_pre an=%b seg=%b want 1101/0000110", an, seg_out);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (an !== 4'hF || seg_out !== 7'h7F || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_23 an=%b seg=%b rdy=%b want 1111/1111111/1",
               an, seg_out, load_ready);
    end
    rst_n = 1'b1;
    repeat (48) begin
      step();
      total++;
      if (an !== 4'hF || seg_out !== 7'h7F || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_after cyc=%0d an=%b seg=%b rdy=%b want 1111/1111111/1",
                 cyc, an, seg_out, load_ready);
      end
    end
    do_reset();
    step();
    step();
    load_valid = 1'b1;
    load_data = 16'h5678;
    step();
    load_valid = 1'b0;
    while (cyc < 8) step();
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL rsths_pend got=%b want=0", load_ready);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (40) begin
      step();
      total++;
      if (an !== 4'hF || seg_out !== 7'h7F || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL rsths_after cyc=%0d an=%b seg=%b rdy=%b want 1111/1111111/1",
                 cyc, an, seg_out, load_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_back_to_back();
    test_boundary_load();
    test_nonbcd();
    test_lz();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
